// File: rtl/csr_issue_ctrl.sv
// Serialises one Zicsr instruction at a time. The request waits for older instructions
// to drain, performs one CSR access cycle, and then returns the old CSR value to writeback.
module csr_issue_ctrl #(
    parameter int XLEN      = 32,
    parameter int CSR_AW    = 12,
    parameter int DRAIN_TMO = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              iss_valid_i,
    output logic              iss_ready_o,
    input  logic [2:0]        iss_funct3_i,
    input  logic [CSR_AW-1:0] iss_csr_addr_i,
    input  logic [XLEN-1:0]   iss_rs1_val_i,
    input  logic [4:0]        iss_rs1_idx_i,
    input  logic [4:0]        iss_rd_i,
    input  logic              pipe_idle_i,
    output logic              csr_valid_o,
    output logic [CSR_AW-1:0] csr_addr_o,
    output logic [XLEN-1:0]   csr_wdata_o,
    output logic [2:0]        csr_cmd_o,
    input  logic [XLEN-1:0]   csr_rdata_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [4:0]        wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              busy_o,
    output logic              illegal_o,
    output logic              drain_err_o
);

    // state  | meaning
    // IDLE   | ready for a new CSR instruction
    // DRAIN  | request latched, waiting for older instructions to retire
    // ACCESS | single cycle on the CSR unit port; read data captured here
    // WB     | old CSR value held on the writeback port until accepted
    typedef enum logic [1:0] {IDLE, DRAIN, ACCESS, WB} state_t;

    localparam logic [7:0] TMO = 8'(DRAIN_TMO);

    state_t            state;
    logic [7:0]        drain_cnt;
    logic [2:0]        f3_q;
    logic [CSR_AW-1:0] addr_q;
    logic [XLEN-1:0]   opnd_q;
    logic [4:0]        rd_q;
    logic              wr_en_q;

    logic accept;
    logic f3_legal;
    logic wr_en;

    assign iss_ready_o = (state == IDLE) && !flush_i;
    assign busy_o      = (state != IDLE);
    assign accept      = iss_valid_i && iss_ready_o;
    assign f3_legal    = (iss_funct3_i[1:0] != 2'b00);
    // Set/clear with a zero source register or zimm is a pure read.
    assign wr_en       = (iss_funct3_i[1:0] == 2'b01) || (iss_rs1_idx_i != 5'd0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            drain_cnt   <= '0;
            f3_q        <= '0;
            addr_q      <= '0;
            opnd_q      <= '0;
            rd_q        <= '0;
            wr_en_q     <= 1'b0;
            csr_valid_o <= 1'b0;
            csr_addr_o  <= '0;
            csr_wdata_o <= '0;
            csr_cmd_o   <= '0;
            wb_valid_o  <= 1'b0;
            wb_rd_o     <= '0;
            wb_data_o   <= '0;
            illegal_o   <= 1'b0;
            drain_err_o <= 1'b0;
        end else begin
            illegal_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (f3_legal) begin
                            f3_q      <= iss_funct3_i;
                            addr_q    <= iss_csr_addr_i;
                            rd_q      <= iss_rd_i;
                            wr_en_q   <= wr_en;
                            opnd_q    <= iss_funct3_i[2] ? {{(XLEN-5){1'b0}}, iss_rs1_idx_i}
                                                         : iss_rs1_val_i;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end else begin
                            illegal_o <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 8'd1;
                    if (flush_i) begin
                        state <= IDLE;
                    end else if (pipe_idle_i) begin
                        csr_valid_o <= wr_en_q;
                        csr_addr_o  <= addr_q;
                        csr_wdata_o <= opnd_q;
                        csr_cmd_o   <= f3_q;
                        state       <= ACCESS;
                    end else if (drain_cnt + 8'd1 == TMO) begin
                        drain_err_o <= 1'b1;
                        state       <= IDLE;
                    end
                end
                ACCESS: begin
                    csr_valid_o <= 1'b0;
                    csr_addr_o  <= '0;
                    csr_wdata_o <= '0;
                    csr_cmd_o   <= '0;
                    wb_valid_o  <= 1'b1;
                    wb_rd_o     <= rd_q;
                    wb_data_o   <= csr_rdata_i;
                    state       <= WB;
                end
                WB: begin
                    if (wb_ready_i) begin
                        wb_valid_o <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_issue_ctrl.sv
// Self-checking bench for csr_issue_ctrl: directed scenarios plus randomized transactions
// checked cycle by cycle against a transaction-level model of the issue timeline.
module tb_csr_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        iss_valid_i;
    logic        iss_ready_o;
    logic [2:0]  iss_funct3_i;
    logic [11:0] iss_csr_addr_i;
    logic [31:0] iss_rs1_val_i;
    logic [4:0]  iss_rs1_idx_i;
    logic [4:0]  iss_rd_i;
    logic        pipe_idle_i;
    logic        csr_valid_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [2:0]  csr_cmd_o;
    logic [31:0] csr_rdata_i;
    logic        wb_valid_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        busy_o;
    logic        illegal_o;
    logic        drain_err_o;

    int   checks = 0;
    int   errors = 0;
    logic drain_err_exp = 1'b0;
    logic [2:0] legal_f3 [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    csr_issue_ctrl #(.XLEN(32), .CSR_AW(12), .DRAIN_TMO(255)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .iss_valid_i(iss_valid_i), .iss_ready_o(iss_ready_o), .iss_funct3_i(iss_funct3_i),
        .iss_csr_addr_i(iss_csr_addr_i), .iss_rs1_val_i(iss_rs1_val_i),
        .iss_rs1_idx_i(iss_rs1_idx_i), .iss_rd_i(iss_rd_i), .pipe_idle_i(pipe_idle_i),
        .csr_valid_o(csr_valid_o), .csr_addr_o(csr_addr_o), .csr_wdata_o(csr_wdata_o),
        .csr_cmd_o(csr_cmd_o), .csr_rdata_i(csr_rdata_i), .wb_valid_o(wb_valid_o),
        .wb_ready_i(wb_ready_i), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .busy_o(busy_o), .illegal_o(illegal_o), .drain_err_o(drain_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #5_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic writes_csr(input logic [2:0] f3, input logic [4:0] idx);
        case (f3)
            3'b001, 3'b101: return 1'b1;
            default:        return idx != 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] operand(input logic [2:0] f3, input logic [31:0] val,
                                            input logic [4:0] idx);
        return f3[2] ? {27'd0, idx} : val;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #2;
    endtask

    task automatic randomize_fields();
        iss_funct3_i   = 3'($urandom);
        iss_csr_addr_i = 12'($urandom);
        iss_rs1_val_i  = $urandom;
        iss_rs1_idx_i  = 5'($urandom);
        iss_rd_i       = 5'($urandom);
    endtask

    task automatic check_reset_outputs();
        check("rst_iss_ready", 64'(iss_ready_o), 64'(1));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_csr_valid", 64'(csr_valid_o), 64'(0));
        check("rst_csr_addr", 64'(csr_addr_o), 64'(0));
        check("rst_csr_wdata", 64'(csr_wdata_o), 64'(0));
        check("rst_csr_cmd", 64'(csr_cmd_o), 64'(0));
        check("rst_wb_valid", 64'(wb_valid_o), 64'(0));
        check("rst_wb_rd", 64'(wb_rd_o), 64'(0));
        check("rst_wb_data", 64'(wb_data_o), 64'(0));
        check("rst_illegal", 64'(illegal_o), 64'(0));
        check("rst_drain_err", 64'(drain_err_o), 64'(0));
    endtask

    // Cycle 0 = accept cycle; idle_delay DRAIN cycles see pipe_idle low, then ACCESS, then WB.
    task automatic run_txn(input logic [2:0] f3, input logic [11:0] addr, input logic [31:0] val,
                           input logic [4:0] idx, input logic [4:0] rd, input logic [31:0] rdata,
                           input int idle_delay, input int wb_delay);
        int acc_k, wb_k, wb_end;
        logic wr, in_acc, in_wb;
        logic [31:0] opnd;
        acc_k  = idle_delay + 2;
        wb_k   = acc_k + 1;
        wb_end = wb_k + wb_delay;
        wr     = writes_csr(f3, idx);
        opnd   = operand(f3, val, idx);
        iss_valid_i = 1'b1; iss_funct3_i = f3; iss_csr_addr_i = addr;
        iss_rs1_val_i = val; iss_rs1_idx_i = idx; iss_rd_i = rd;
        flush_i = 1'b0; pipe_idle_i = 1'($urandom); wb_ready_i = 1'($urandom);
        csr_rdata_i = $urandom;
        #1;
        check("txn_accept_ready", 64'(iss_ready_o), 64'(1));
        for (int k = 1; k <= wb_end + 1; k++) begin
            step();
            randomize_fields();
            iss_valid_i = (k <= wb_end) ? 1'($urandom) : 1'b0;
            pipe_idle_i = (k <= idle_delay) ? 1'b0 : (k == idle_delay + 1) ? 1'b1 : 1'($urandom);
            flush_i     = (k < acc_k || k > wb_end) ? 1'b0 : 1'($urandom);
            wb_ready_i  = (k < wb_k) ? 1'($urandom) : (k < wb_end) ? 1'b0 :
                          (k == wb_end) ? 1'b1 : 1'($urandom);
            csr_rdata_i = (k == acc_k) ? rdata : $urandom;
            #1;
            in_acc = (k == acc_k);
            in_wb  = (k >= wb_k) && (k <= wb_end);
            check("txn_busy", 64'(busy_o), 64'(k <= wb_end));
            check("txn_iss_ready", 64'(iss_ready_o), 64'(k > wb_end));
            check("txn_csr_valid", 64'(csr_valid_o), 64'(in_acc && wr));
            check("txn_csr_addr", 64'(csr_addr_o), in_acc ? 64'(addr) : 64'(0));
            check("txn_csr_wdata", 64'(csr_wdata_o), in_acc ? 64'(opnd) : 64'(0));
            check("txn_csr_cmd", 64'(csr_cmd_o), in_acc ? 64'(f3) : 64'(0));
            check("txn_wb_valid", 64'(wb_valid_o), 64'(in_wb));
            if (in_wb) begin
                check("txn_wb_rd", 64'(wb_rd_o), 64'(rd));
                check("txn_wb_data", 64'(wb_data_o), 64'(rdata));
            end
            check("txn_illegal", 64'(illegal_o), 64'(0));
            check("txn_drain_err", 64'(drain_err_o), 64'(drain_err_exp));
        end
    endtask

    // Flush arrives in DRAIN cycle f+1; the request must vanish without any CSR activity.
    task automatic run_flush(input logic [2:0] f3, input int f);
        iss_valid_i = 1'b1; iss_funct3_i = f3; iss_csr_addr_i = 12'($urandom);
        iss_rs1_val_i = $urandom; iss_rs1_idx_i = 5'($urandom); iss_rd_i = 5'($urandom);
        flush_i = 1'b0; pipe_idle_i = 1'b0;
        #1;
        check("flush_accept_ready", 64'(iss_ready_o), 64'(1));
        for (int k = 1; k <= f + 2; k++) begin
            step();
            randomize_fields();
            iss_valid_i = (k <= f + 1) ? 1'($urandom) : 1'b0;
            pipe_idle_i = (k <= f) ? 1'b0 : 1'($urandom);
            flush_i     = (k == f + 1);
            wb_ready_i  = 1'($urandom);
            csr_rdata_i = $urandom;
            #1;
            check("flush_busy", 64'(busy_o), 64'(k <= f + 1));
            check("flush_iss_ready", 64'(iss_ready_o), 64'(k == f + 2));
            check("flush_csr_valid", 64'(csr_valid_o), 64'(0));
            check("flush_wb_valid", 64'(wb_valid_o), 64'(0));
            check("flush_drain_err", 64'(drain_err_o), 64'(drain_err_exp));
        end
    endtask

    task automatic run_illegal(input logic [2:0] f3);
        iss_valid_i = 1'b1; iss_funct3_i = f3; iss_rs1_idx_i = 5'($urandom);
        flush_i = 1'b0; pipe_idle_i = 1'($urandom);
        #1;
        check("ill_ready", 64'(iss_ready_o), 64'(1));
        for (int k = 1; k <= 2; k++) begin
            step();
            iss_valid_i = 1'b0;
            #1;
            check("ill_pulse", 64'(illegal_o), 64'(k == 1));
            check("ill_busy", 64'(busy_o), 64'(0));
            check("ill_csr_valid", 64'(csr_valid_o), 64'(0));
            check("ill_wb_valid", 64'(wb_valid_o), 64'(0));
        end
    endtask

    initial begin
        logic [2:0] f3;
        logic [4:0] idx;
        int sel;

        rst_ni = 1'b0; flush_i = 1'b0; iss_valid_i = 1'b0; iss_funct3_i = '0;
        iss_csr_addr_i = '0; iss_rs1_val_i = '0; iss_rs1_idx_i = '0; iss_rd_i = '0;
        pipe_idle_i = 1'b0; csr_rdata_i = '0; wb_ready_i = 1'b0;
        #3;
        check_reset_outputs();
        step(); step();
        rst_ni = 1'b1;
        #1;
        check("post_rst_ready", 64'(iss_ready_o), 64'(1));

        // CSRRW x5, 0x300: wb_valid three cycles after accept
        run_txn(3'b001, 12'h300, 32'hDEADBEEF, 5'd9, 5'd5, 32'h0000_1800, 0, 0);
        // CSRRW with rs1 index 0 and rd 0 still writes
        run_txn(3'b001, 12'h340, 32'h1234_5678, 5'd0, 5'd0, 32'hCAFE_0001, 0, 1);
        // CSRRS/CSRRSI with zero source: read-only access
        run_txn(3'b010, 12'hC00, 32'hFFFF_FFFF, 5'd0, 5'd7, 32'h0BAD_F00D, 0, 0);
        run_txn(3'b110, 12'hC00, 32'hFFFF_FFFF, 5'd0, 5'd7, 32'h0BAD_F00D, 0, 0);
        // CSRRCI zimm=0x1F with a 10-cycle drain
        run_txn(3'b111, 12'h300, 32'h0, 5'h1F, 5'd3, 32'h0000_0088, 10, 0);
        // flush in DRAIN, then a fresh issue is accepted
        run_flush(3'b011, 3);
        run_txn(3'b011, 12'h305, 32'h0000_00F0, 5'd4, 5'd8, 32'h8000_0000, 1, 0);
        // illegal funct3 values
        run_illegal(3'b100);
        run_illegal(3'b000);
        // writeback back-pressure for 5 cycles
        run_txn(3'b101, 12'h7C0, 32'h0, 5'h15, 5'd31, 32'h5A5A_A5A5, 2, 5);

        // flush together with a valid issue in IDLE: nothing accepted
        iss_valid_i = 1'b1; iss_funct3_i = 3'b001; flush_i = 1'b1;
        #1;
        check("idle_flush_ready", 64'(iss_ready_o), 64'(0));
        step();
        iss_funct3_i = 3'b100;
        #1;
        check("idle_flush_busy", 64'(busy_o), 64'(0));
        step();
        iss_valid_i = 1'b0; flush_i = 1'b0;
        #1;
        check("idle_flush_illegal", 64'(illegal_o), 64'(0));
        check("idle_flush_busy2", 64'(busy_o), 64'(0));

        for (int t = 0; t < 40; t++) begin
            sel = int'($urandom_range(0, 9));
            f3  = legal_f3[int'($urandom_range(0, 5))];
            idx = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            if (sel == 0)
                run_illegal({1'($urandom), 2'b00});
            else if (sel == 1)
                run_flush(f3, int'($urandom_range(0, 4)));
            else
                run_txn(f3, 12'($urandom), $urandom, idx, 5'($urandom), $urandom,
                        int'($urandom_range(0, 6)), int'($urandom_range(0, 4)));
        end

        // drain timeout: pipe never idle
        iss_valid_i = 1'b1; iss_funct3_i = 3'b010; iss_rs1_idx_i = 5'd2; flush_i = 1'b0;
        pipe_idle_i = 1'b0;
        #1;
        check("tmo_ready", 64'(iss_ready_o), 64'(1));
        for (int k = 1; k <= 256; k++) begin
            step();
            iss_valid_i = 1'b0;
            #1;
            check("tmo_busy", 64'(busy_o), 64'(k <= 255));
            check("tmo_csr_valid", 64'(csr_valid_o), 64'(0));
            check("tmo_err", 64'(drain_err_o), 64'(k == 256));
        end
        drain_err_exp = 1'b1;
        run_txn(3'b001, 12'h300, 32'h0000_0001, 5'd1, 5'd1, 32'h0000_0002, 0, 0);

        // async reset while holding a result in WB
        iss_valid_i = 1'b1; iss_funct3_i = 3'b001; iss_csr_addr_i = 12'h300;
        iss_rs1_val_i = 32'hA5A5_0000; iss_rd_i = 5'd6; pipe_idle_i = 1'b1; wb_ready_i = 1'b0;
        csr_rdata_i = 32'h1111_2222;
        step(); iss_valid_i = 1'b0;
        step(); step();
        #1;
        check("rstwb_wb_valid", 64'(wb_valid_o), 64'(1));
        check("rstwb_wb_data", 64'(wb_data_o), 64'h1111_2222);
        #1;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs();
        drain_err_exp = 1'b0;
        step(); step();
        rst_ni = 1'b1;
        run_txn(3'b011, 12'h001, 32'h0000_0003, 5'd12, 5'd10, 32'h0000_00FF, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
